// File: rtl/mips_pkg.sv
// Shared MIPS front-end types and constants: fetch FSM states, reset PC, J-type opcode.
package mips_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned OPW  = 6;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [OPW-1:0]  J_OP             = 6'h02;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      VALID = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
interface instr_fetch_if;

   logic                       imem_req;
   logic [mips_pkg::XLEN-1:0]  imem_addr;
   logic                       imem_gnt;
   logic                       imem_rvalid;
   logic [mips_pkg::XLEN-1:0]  imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/pc_next.sv
// Combinational next-PC select: jump (when FETCH_JUMP_EN is defined), then taken branch, then sequential.
module pc_next
   import mips_pkg::*;
(
   input  logic [XLEN-1:0] pc_plus4_i,
   input  logic [25:0]     instr_index_i,
   input  logic            branch_i,
   input  logic            zero_i,
   input  logic            jump_i,
   input  logic [XLEN-1:0] imm_ext_i,
   output logic [XLEN-1:0] next_pc_c
);

   logic [XLEN-1:0] br_target_c;

   assign br_target_c = pc_plus4_i + (imm_ext_i << 2);

`ifdef FETCH_JUMP_EN
   logic [XLEN-1:0] j_target_c;

   assign j_target_c = {pc_plus4_i[XLEN-1:XLEN-4], instr_index_i, 2'b00};

   always_comb begin
      next_pc_c = pc_plus4_i;
      if (jump_i) begin
         next_pc_c = j_target_c;
      end else if (branch_i && zero_i) begin
         next_pc_c = br_target_c;
      end
   end
`else
   // Jump support compiled out; the port stays so the decode hookup is identical.
   logic unused_jump_c;
   assign unused_jump_c = ^{jump_i, instr_index_i};

   always_comb begin
      next_pc_c = pc_plus4_i;
      if (branch_i && zero_i) begin
         next_pc_c = br_target_c;
      end
   end
`endif

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/FETCH/WAIT/VALID request FSM, PC update on retire, retire counter.
// Optional jump target selection is enabled by defining FETCH_JUMP_EN.
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   instr_fetch_if.master     bus,
   output logic [XLEN-1:0]   instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              branch,
   input  logic              zero,
   input  logic [XLEN-1:0]   imm_ext,
   input  logic              jump,
   output logic [XLEN-1:0]   pc,
   output logic [XLEN-1:0]   pc_plus4,
   output logic [XLEN-1:0]   retired
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
   localparam logic [XLEN-1:0] PC_RST     = RESET_PC & ALIGN_MASK;
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc4_q, pc4_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] retired_q, retired_d;
   logic            valid_q, valid_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] npc_c;

   pc_next u_pc_next (
      .pc_plus4_i    (pc4_q),
      .instr_index_i (instr_q[25:0]),
      .branch_i      (branch),
      .zero_i        (zero),
      .jump_i        (jump),
      .imm_ext_i     (imm_ext),
      .next_pc_c     (npc_c)
   );

   // Next-state and registered-output logic; decode flags only matter on the retire edge.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pc4_d     = pc4_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      valid_d   = valid_q;
      req_d     = req_q;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
            req_d   = 1'b1;
         end
         FETCH: begin
            if (bus.imem_gnt) begin
               state_d = WAIT;
               req_d   = 1'b0;
            end
         end
         WAIT: begin
            if (bus.imem_rvalid) begin
               state_d = VALID;
               instr_d = bus.imem_rdata;
               valid_d = 1'b1;
            end
         end
         VALID: begin
            if (instr_ready) begin
               state_d   = FETCH;
               valid_d   = 1'b0;
               req_d     = 1'b1;
               pc_d      = npc_c & ALIGN_MASK;
               pc4_d     = pc_d + PC_STEP;
               retired_d = retired_q + XLEN'(1);
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc_q      <= PC_RST;
         pc4_q     <= PC_RST + PC_STEP;
         instr_q   <= '0;
         retired_q <= '0;
         valid_q   <= 1'b0;
         req_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pc4_q     <= pc4_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
         valid_q   <= valid_d;
         req_q     <= req_d;
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = pc_q;
   assign instr         = instr_q;
   assign instr_valid   = valid_q;
   assign pc            = pc_q;
   assign pc_plus4      = pc4_q;
   assign retired       = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset/throughput, table of retire vectors, reset-in-WAIT and PC wrap.
module tb_instr_fetch;

   typedef struct {
      logic [31:0] rdata;
      logic        b;
      logic        z;
      logic        j;
      logic [31:0] imm;
      int          gw;
      int          rw;
      int          hw;
      logic [31:0] exp_j;
      logic [31:0] exp_nj;
   } vec_t;

`ifdef FETCH_JUMP_EN
   localparam bit JEN = 1'b1;
`else
   localparam bit JEN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        branch;
   logic        zero;
   logic [31:0] imm_ext;
   logic        jump;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] retired;

   int n_cmp = 0;
   int n_err = 0;

   instr_fetch_if bus ();

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .branch      (branch),
      .zero        (zero),
      .imm_ext     (imm_ext),
      .jump        (jump),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .retired     (retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Decode flags that would redirect the PC if they were not ignored outside the retire edge.
   task automatic garbage_flags();
      branch  = 1'b1;
      zero    = 1'b1;
      jump    = 1'b1;
      imm_ext = 32'h1234_5678;
   endtask

   // One full transaction starting in FETCH with gnt low; ends one cycle after the retire edge.
   task automatic fetch_one(input vec_t v, input logic [31:0] cur_pc,
                            input logic [31:0] nxt, input logic [31:0] ret);
      for (int k = 0; k < v.gw; k++) begin
         bus.imem_gnt    = 1'b0;
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = 32'hDEAD_BEEF;
         garbage_flags();
         @(posedge clk); #1;
         chk("req_held", 32'(bus.imem_req), 32'd1);
         chk("addr_held", bus.imem_addr, cur_pc);
      end
      bus.imem_gnt    = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      chk("req_drop", 32'(bus.imem_req), 32'd0);
      chk("valid_wait", 32'(instr_valid), 32'd0);
      for (int k = 0; k < v.rw; k++) begin
         @(posedge clk); #1;
         chk("valid_stall", 32'(instr_valid), 32'd0);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = v.rdata;
      @(posedge clk); #1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      chk("valid_set", 32'(instr_valid), 32'd1);
      chk("instr_cap", instr, v.rdata);
      chk("pc_of_instr", pc, cur_pc);
      for (int k = 0; k < v.hw; k++) begin
         @(posedge clk); #1;
         chk("instr_hold", instr, v.rdata);
         chk("pc_hold", pc, cur_pc);
         chk("valid_hold", 32'(instr_valid), 32'd1);
      end
      instr_ready = 1'b1;
      branch      = v.b;
      zero        = v.z;
      jump        = v.j;
      imm_ext     = v.imm;
      @(posedge clk); #1;
      instr_ready     = 1'b0;
      bus.imem_rvalid = 1'b0;
      garbage_flags();
      chk("next_pc", pc, nxt);
      chk("pc_plus4", pc_plus4, nxt + 32'd4);
      chk("retired", retired, ret);
      chk("valid_clr", 32'(instr_valid), 32'd0);
      chk("req_refetch", 32'(bus.imem_req), 32'd1);
      chk("addr_refetch", bus.imem_addr, nxt);
   endtask

   vec_t        tbl [8];
   vec_t        wv;
   logic [31:0] exp_pc;
   logic [31:0] exp_ret;
   logic [31:0] nxt;

   initial begin
      //              rdata         b     z     j     imm            gw rw hw exp_j          exp_nj
      tbl[0] = '{32'h1000_000B, 1'b1, 1'b1, 1'b0, 32'h0000_000B, 5, 0, 3, 32'h0000_0040, 32'h0000_0040};
      tbl[1] = '{32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 0, 2, 0, 32'h0000_003C, 32'h0000_003C};
      tbl[2] = '{32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1, 0, 1, 32'h0000_0040, 32'h0000_0040};
      tbl[3] = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 0, 0, 0, 32'h0000_0044, 32'h0000_0044};
      tbl[4] = '{32'h0022_1820, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 0, 1, 0, 32'h0000_0048, 32'h0000_0048};
      tbl[5] = '{32'h1000_FFED, 1'b1, 1'b1, 1'b0, 32'h03FF_FFED, 0, 0, 0, 32'h1000_0000, 32'h1000_0000};
      tbl[6] = '{32'h0800_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 0, 0, 0, 32'h1000_0400, 32'h1000_0004};
      tbl[7] = '{32'h0800_0040, 1'b1, 1'b1, 1'b1, 32'h0000_0004, 0, 0, 0, 32'h1000_0100, 32'h1000_0018};

      // Reset with gnt/rvalid/ready tied high.
      rst_n           = 1'b0;
      bus.imem_gnt    = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'h0000_0020;
      instr_ready     = 1'b1;
      branch          = 1'b0;
      zero            = 1'b0;
      jump            = 1'b0;
      imm_ext         = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", pc, 32'h0);
      chk("rst_pc4", pc_plus4, 32'h4);
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_retired", retired, 32'h0);
      chk("rst_addr", bus.imem_addr, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("c1_req", 32'(bus.imem_req), 32'd1);
      chk("c1_addr", bus.imem_addr, 32'h0);
      chk("c1_valid", 32'(instr_valid), 32'd0);
      @(posedge clk); #1;
      chk("c2_valid", 32'(instr_valid), 32'd0);
      @(posedge clk); #1;
      chk("c3_valid", 32'(instr_valid), 32'd1);
      chk("c3_instr", instr, 32'h0000_0020);
      repeat (10) @(posedge clk);
      #1;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      instr_ready     = 1'b0;
      chk("four_pc", pc, 32'h0000_0010);
      chk("four_retired", retired, 32'd4);
      chk("four_req", 32'(bus.imem_req), 32'd1);

      // Table of retire vectors chained from pc=0x10.
      exp_pc  = 32'h0000_0010;
      exp_ret = 32'd4;
      for (int i = 0; i < 8; i++) begin
         nxt     = JEN ? tbl[i].exp_j : tbl[i].exp_nj;
         exp_ret = exp_ret + 32'd1;
         fetch_one(tbl[i], exp_pc, nxt, exp_ret);
         exp_pc = nxt;
      end

      // Reset while waiting for data, then a late response must be dropped.
      bus.imem_gnt = 1'b1;
      @(posedge clk); #1;
      bus.imem_gnt = 1'b0;
      chk("wait_valid", 32'(instr_valid), 32'd0);
      rst_n = 1'b0;
      #2;
      chk("async_pc", pc, 32'h0);
      chk("async_instr", instr, 32'h0);
      chk("async_req", 32'(bus.imem_req), 32'd0);
      chk("async_retired", retired, 32'h0);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hCAFE_F00D;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("late_instr", instr, 32'h0);
      chk("late_valid", 32'(instr_valid), 32'd0);
      chk("late_req", 32'(bus.imem_req), 32'd1);
      chk("late_addr", bus.imem_addr, 32'h0);
      @(posedge clk); #1;
      chk("late_instr2", instr, 32'h0);
      chk("late_valid2", 32'(instr_valid), 32'd0);
      bus.imem_rvalid = 1'b0;

      // Backward branch from 0 wraps to 0xFFFF_FFFC, then sequential wraps to 0.
      wv = '{32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
      fetch_one(wv, 32'h0, 32'hFFFF_FFFC, 32'd1);
      wv = '{32'h0000_0020, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 0, 0, 1, 32'h0000_0000, 32'h0000_0000};
      fetch_one(wv, 32'hFFFF_FFFC, 32'h0, 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
